lcd_responder: RTL and testbench



---
 rtl/lcd_pkg.sv | 25 ++
 rtl/lcd_addr_step.sv | 36 +++
 rtl/lcd_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_lcd_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus responder:
// bus control encodings, controller states and DDRAM geometry.
package lcd_pkg;

    localparam logic [1:0] CTRL_CMD  = 2'b00;
    localparam logic [1:0] CTRL_STAT = 2'b01;
    localparam logic [1:0] CTRL_DATA = 2'b10;
    localparam logic [1:0] CTRL_READ = 2'b11;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        BUSY  = 2'd2
    } lcd_state_e;

    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam int         LINE_LEN   = 16;
    localparam logic [7:0] SPACE      = 8'h20;

    // Visible addresses are 0x00-0x0F and 0x40-0x4F, so bits [5:4] must be zero.
    function automatic logic addr_is_valid(input logic [6:0] a);
        return (a & 7'b0110000) == 7'b0000000;
    endfunction

endpackage

// File: rtl/lcd_addr_step.sv
// Next cursor address for one step in either direction, wrapping
// line 0 end into line 1 and line 1 end back to the origin.
import lcd_pkg::*;

module lcd_addr_step (
    input  logic [6:0] addr,
    input  logic       inc,
    output logic [6:0] addr_next
);

    localparam logic [6:0] LINE0_LAST = 7'(LINE_LEN - 1);
    localparam logic [6:0] LINE1_LAST = LINE1_BASE + LINE0_LAST;

    // Wrapping increment / decrement of the cursor address
    always_comb begin
        addr_next = addr;
        if (inc) begin
            if (addr == LINE0_LAST) begin
                addr_next = LINE1_BASE;
            end else if (addr == LINE1_LAST) begin
                addr_next = 7'h00;
            end else begin
                addr_next = addr + 7'd1;
            end
        end else begin
            if (addr == 7'h00) begin
                addr_next = LINE1_LAST;
            end else if (addr == LINE1_BASE) begin
                addr_next = LINE0_LAST;
            end else begin
                addr_next = addr - 7'd1;
            end
        end
    end

endmodule

// File: rtl/lcd_responder.sv
// Device-side model of an HD44780-style 8-bit LCD: decodes host strobes,
// keeps a 2x16 DDRAM, cursor, entry mode, busy flag and sticky error.
import lcd_pkg::*;

module lcd_responder #(
    parameter int BUSY_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] lcd_data,
    input  logic [1:0] lcd_ctrl,
    input  logic       lcd_enable,
    output logic [7:0] lcd_rdata,
    output logic       busy,
    output logic       err,
    output logic       char_valid,
    output logic [7:0] char_data,
    input  logic [4:0] fb_addr,
    output logic [7:0] fb_data
);

    localparam int CNT_W = $clog2(CLEAR_CYCLES + BUSY_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_CYCLES - 1);

    logic             en_s1_r, en_s2_r, en_prev_r;
    logic             fall_s;
    lcd_state_e       state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [5:0]       sweep_r, sweep_n;
    logic [6:0]       addr_r, addr_n, step_addr_s;
    logic             inc_r, inc_n;
    logic             display_on_r, display_on_n;
    logic             err_r, err_n;
    logic             busy_r;
    logic             char_valid_r, char_valid_n;
    logic [7:0]       char_data_r, char_data_n;
    logic [7:0]       rdata_r, rdata_n;
    logic [7:0]       ddram_r [32];
    logic             we_s;
    logic [4:0]       waddr_s, idx_s;
    logic [7:0]       wdata_s;
    logic             step_dir_s;

    assign fall_s     = en_prev_r & ~en_s2_r;
    assign idx_s      = {addr_r[6], addr_r[3:0]};
    assign step_dir_s = (lcd_ctrl == CTRL_CMD) ? lcd_data[2] : inc_r;

    lcd_addr_step u_addr_step (
        .addr      (addr_r),
        .inc       (step_dir_s),
        .addr_next (step_addr_s)
    );

    // Enable synchronizer and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_s1_r   <= 1'b0;
            en_s2_r   <= 1'b0;
            en_prev_r <= 1'b0;
        end else begin
            en_s1_r   <= lcd_enable;
            en_s2_r   <= en_s1_r;
            en_prev_r <= en_s2_r;
        end
    end

    // Controller state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= CLEAR;
            cnt_r        <= CNT_ZERO;
            sweep_r      <= 6'd0;
            addr_r       <= 7'h00;
            inc_r        <= 1'b1;
            display_on_r <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b1;
            char_valid_r <= 1'b0;
            char_data_r  <= 8'h00;
            rdata_r      <= 8'h00;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            sweep_r      <= sweep_n;
            addr_r       <= addr_n;
            inc_r        <= inc_n;
            display_on_r <= display_on_n;
            err_r        <= err_n;
            busy_r       <= (state_n != IDLE);
            char_valid_r <= char_valid_n;
            char_data_r  <= char_data_n;
            rdata_r      <= rdata_n;
        end
    end

    // DDRAM write port (sweep or host data write)
    always_ff @(posedge clk) begin
        if (we_s) begin
            ddram_r[waddr_s] <= wdata_s;
        end
    end

    // Next-state, transaction decode and read-back mux
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        sweep_n      = sweep_r;
        addr_n       = addr_r;
        inc_n        = inc_r;
        display_on_n = display_on_r;
        err_n        = err_r;
        char_valid_n = 1'b0;
        char_data_n  = char_data_r;
        we_s         = 1'b0;
        waddr_s      = idx_s;
        wdata_s      = lcd_data;
        rdata_n      = 8'h00;

        case (state_r)
            CLEAR: begin
                if (!sweep_r[5]) begin
                    we_s    = 1'b1;
                    waddr_s = sweep_r[4:0];
                    wdata_s = SPACE;
                    sweep_n = sweep_r + 6'd1;
                end else begin
                    sweep_n = sweep_r;
                end
                if (cnt_r == CLEAR_LAST) begin
                    state_n = IDLE;
                    cnt_n   = CNT_ZERO;
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            BUSY: begin
                if (cnt_r == BUSY_LAST) begin
                    state_n = IDLE;
                    cnt_n   = CNT_ZERO;
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            IDLE:    cnt_n   = CNT_ZERO;
            default: state_n = CLEAR;
        endcase

        // Writes are only accepted in IDLE; a data read during the sweep would abort it, so it is left alone
        if (fall_s) begin
            case (lcd_ctrl)
                CTRL_CMD, CTRL_DATA: begin
                    if (state_r != IDLE) begin
                        err_n = 1'b1;
                    end else if (lcd_ctrl == CTRL_DATA) begin
                        we_s         = 1'b1;
                        waddr_s      = idx_s;
                        wdata_s      = lcd_data;
                        char_valid_n = 1'b1;
                        char_data_n  = lcd_data;
                        addr_n       = step_addr_s;
                        state_n      = BUSY;
                        cnt_n        = CNT_ZERO;
                    end else begin
                        state_n = BUSY;
                        cnt_n   = CNT_ZERO;
                        casez (lcd_data)
                            8'b1???????: begin
                                if (addr_is_valid(lcd_data[6:0])) begin
                                    addr_n = lcd_data[6:0];
                                end else begin
                                    addr_n = 7'h00;
                                    err_n  = 1'b1;
                                end
                            end
                            8'b01??????, 8'b001?????: addr_n = addr_r;
                            8'b0001????: begin
                                if (!lcd_data[3]) begin
                                    addr_n = step_addr_s;
                                end else begin
                                    addr_n = addr_r;
                                end
                            end
                            8'b00001???: display_on_n = lcd_data[2];
                            8'b000001??: inc_n = lcd_data[1];
                            8'b0000001?: addr_n = 7'h00;
                            8'b00000001: begin
                                state_n = CLEAR;
                                sweep_n = 6'd0;
                                addr_n  = 7'h00;
                                inc_n   = 1'b1;
                            end
                            default: addr_n = addr_r;
                        endcase
                    end
                end
                CTRL_READ: begin
                    if (state_r != CLEAR) begin
                        addr_n  = step_addr_s;
                        state_n = BUSY;
                        cnt_n   = CNT_ZERO;
                    end else begin
                        addr_n = addr_r;
                    end
                end
                default: addr_n = addr_r;
            endcase
        end else begin
            err_n = err_r;
        end

        if (en_s2_r) begin
            case (lcd_ctrl)
                CTRL_STAT: rdata_n = {busy_r, addr_r};
                CTRL_READ: rdata_n = ddram_r[idx_s];
                default:   rdata_n = 8'h00;
            endcase
        end else begin
            rdata_n = 8'h00;
        end
    end

    assign lcd_rdata  = rdata_r;
    assign busy       = busy_r;
    assign err        = err_r;
    assign char_valid = char_valid_r;
    assign char_data  = char_data_r;
    assign fb_data    = ddram_r[fb_addr];

endmodule

// File: tb/tb_lcd_responder.sv
// Scoreboard bench for lcd_responder: expected characters and read-back
// values are queued by the stimulus and consumed by a separate monitor.
import lcd_pkg::*;

module tb_lcd_responder;

    localparam int BUSY_CYCLES  = 4;
    localparam int CLEAR_CYCLES = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] lcd_data;
    logic [1:0] lcd_ctrl;
    logic       lcd_enable;
    logic [7:0] lcd_rdata;
    logic       busy, err, char_valid;
    logic [7:0] char_data;
    logic [4:0] fb_addr;
    logic [7:0] fb_data;

    int checks = 0;
    int errors = 0;
    int run_len = 0;
    int last_run = 0;
    logic rd_sample = 1'b0;
    logic [7:0] char_q [$];
    logic [7:0] rd_q [$];
    string      rd_name_q [$];
    logic [7:0] exp_v;
    string      exp_n;

    lcd_responder #(.BUSY_CYCLES(BUSY_CYCLES), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .lcd_ctrl(lcd_ctrl),
        .lcd_enable(lcd_enable), .lcd_rdata(lcd_rdata), .busy(busy), .err(err),
        .char_valid(char_valid), .char_data(char_data), .fb_addr(fb_addr), .fb_data(fb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: consumes the scoreboard whenever the DUT presents a character or a read
    always @(negedge clk) begin
        if (char_valid === 1'b1) begin
            checks++;
            if (char_q.size() == 0) begin
                errors++;
                $display("FAIL char_unexpected: got 0x%02h, required no character", char_data);
            end else begin
                exp_v = char_q.pop_front();
                if (char_data !== exp_v) begin
                    errors++;
                    $display("FAIL char_data: got 0x%02h, required 0x%02h", char_data, exp_v);
                end
            end
        end
        if (rd_sample && rd_q.size() != 0) begin
            checks++;
            exp_v = rd_q.pop_front();
            exp_n = rd_name_q.pop_front();
            if (lcd_rdata !== exp_v) begin
                errors++;
                $display("FAIL %s: got 0x%02h, required 0x%02h", exp_n, lcd_rdata, exp_v);
            end
        end
    end

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            run_len++;
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
    end

    task automatic bus_write(input logic [1:0] c, input logic [7:0] d);
        @(posedge clk); #1;
        if (c == CTRL_DATA) char_q.push_back(d);
        lcd_ctrl = c; lcd_data = d; lcd_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 lcd_enable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] c, input logic [7:0] exp, input string nm);
        @(posedge clk); #1;
        lcd_ctrl = c; lcd_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 rd_q.push_back(exp); rd_name_q.push_back(nm); rd_sample = 1'b1;
        @(posedge clk);
        #1 rd_sample = 1'b0; lcd_enable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic cmd(input logic [7:0] d);
        bus_write(CTRL_CMD, d);
        wait_idle(BUSY_CYCLES + 20, "cmd_idle");
    endtask

    task automatic dwr(input logic [7:0] d);
        bus_write(CTRL_DATA, d);
        wait_idle(BUSY_CYCLES + 20, "data_idle");
    endtask

    task automatic check_fb(input int idx, input logic [7:0] exp, input string nm);
        fb_addr = 5'(idx);
        #1 check(nm, {24'd0, fb_data}, {24'd0, exp});
    endtask

    task automatic check_fb_all_space(input string nm);
        for (int i = 0; i < 32; i++) check_fb(i, 8'h20, nm);
    endtask

    task automatic do_reset(input int hold);
        lcd_enable = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_char_valid", {31'd0, char_valid}, 32'd0);
        check("rst_char_data", {24'd0, char_data}, 32'd0);
        check("rst_rdata", {24'd0, lcd_rdata}, 32'd0);
        repeat (hold) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle(CLEAR_CYCLES + 40, "clear_idle");
        check("clear_len_ok", {31'd0, (last_run >= CLEAR_CYCLES)}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; lcd_enable = 1'b0; lcd_ctrl = CTRL_CMD; lcd_data = 8'h00; fb_addr = 5'd0;
        #2 do_reset(3);
        check_fb_all_space("fb_after_reset");
        bus_read(CTRL_STAT, 8'h00, "status_after_reset");
        check("rdata_enable_low", {24'd0, lcd_rdata}, 32'd0);
        check("err_after_reset", {31'd0, err}, 32'd0);

        // Hello: two characters from home, then a data read-back
        cmd(8'h80);
        check("busy_len", last_run, BUSY_CYCLES);
        dwr(8'h48);
        dwr(8'h69);
        check_fb(0, 8'h48, "fb0_H");
        check_fb(1, 8'h69, "fb1_i");
        bus_read(CTRL_STAT, 8'h02, "status_after_Hi");
        cmd(8'h80);
        bus_read(CTRL_READ, 8'h48, "data_read_fb0");
        wait_idle(BUSY_CYCLES + 20, "read_idle");
        bus_read(CTRL_STAT, 8'h01, "status_after_read");

        // Line wrap forward, then decrement mode wrap backward
        cmd(8'h8F);
        dwr(8'h41);
        dwr(8'h42);
        check_fb(15, 8'h41, "fb15_A");
        check_fb(16, 8'h42, "fb16_B");
        bus_read(CTRL_STAT, 8'h41, "status_after_AB");
        cmd(8'h04);
        cmd(8'h80);
        dwr(8'h5A);
        check_fb(0, 8'h5A, "fb0_Z");
        bus_read(CTRL_STAT, 8'h4F, "status_dec_wrap");
        cmd(8'h14);
        bus_read(CTRL_STAT, 8'h00, "status_shift_right");
        cmd(8'h10);
        bus_read(CTRL_STAT, 8'h4F, "status_shift_left");
        cmd(8'h18);
        bus_read(CTRL_STAT, 8'h4F, "status_display_shift");
        cmd(8'h06);
        cmd(8'hC5);
        bus_read(CTRL_STAT, 8'h45, "status_set_45");
        check("err_clean_session", {31'd0, err}, 32'd0);

        // Out-of-range DDRAM address
        cmd(8'hA0);
        bus_read(CTRL_STAT, 8'h00, "status_bad_addr");
        check("err_bad_addr", {31'd0, err}, 32'd1);

        do_reset(3);
        check_fb_all_space("fb_after_reset2");

        // Second strobe lands while the first write is still busy
        cmd(8'hC0);
        @(posedge clk); #1;
        char_q.push_back(8'h58);
        lcd_ctrl = CTRL_DATA; lcd_data = 8'h58; lcd_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 lcd_enable = 1'b0;
        @(posedge clk); #1 lcd_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1 lcd_enable = 1'b0; lcd_data = 8'h59;
        repeat (5) @(posedge clk); #1;
        wait_idle(BUSY_CYCLES + 20, "busy_test_idle");
        check_fb(16, 8'h58, "fb16_X");
        check_fb(17, 8'h20, "fb17_unchanged");
        check("err_write_busy", {31'd0, err}, 32'd1);
        bus_read(CTRL_STAT, 8'h41, "status_busy_test");
        dwr(8'h43);
        check_fb(17, 8'h43, "fb17_C");
        bus_read(CTRL_STAT, 8'h42, "status_after_C");
        check("err_sticky", {31'd0, err}, 32'd1);

        // Clear mid-session restores spaces, home and increment mode
        cmd(8'h04);
        bus_write(CTRL_CMD, 8'h01);
        wait_idle(CLEAR_CYCLES + 40, "clear_cmd_idle");
        check("clear_cmd_len_ok", {31'd0, (last_run >= CLEAR_CYCLES)}, 32'd1);
        check_fb_all_space("fb_after_clear_cmd");
        bus_read(CTRL_STAT, 8'h00, "status_after_clear");
        check("err_after_clear", {31'd0, err}, 32'd1);
        dwr(8'h4B);
        check_fb(0, 8'h4B, "fb0_K");
        bus_read(CTRL_STAT, 8'h01, "status_inc_restored");

        // Reset pulsed partway through a clear sweep
        cmd(8'hCF);
        dwr(8'h51);
        check_fb(31, 8'h51, "fb31_Q");
        bus_write(CTRL_CMD, 8'h01);
        repeat (8) @(posedge clk);
        #1 do_reset(2);
        check_fb_all_space("fb_after_mid_reset");
        bus_read(CTRL_STAT, 8'h00, "status_after_mid_reset");

        repeat (4) @(posedge clk);
        check("char_q_empty", char_q.size(), 32'd0);
        check("rd_q_empty", rd_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
